// File: rtl/inv_permute_stream_pkg.sv
// Shared definitions for the permute / inverse-permute stream blocks.
//   LINES  : slice lines per frame
//   WIDTH  : bits per slice line (fixed 5x5 lane grid)
//   CNT_W  : frame counter width, wide enough to hold LINES itself
//   idx()  : lane (x,y) -> bit index within a line
//   state_e: control FSM states
package inv_permute_stream_pkg;

    localparam int unsigned LINES = 64;
    localparam int unsigned WIDTH = 25;
    localparam int unsigned CNT_W = $clog2(LINES) + 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    function automatic int unsigned idx(input int unsigned x, input int unsigned y);
        return 5 * y + x;
    endfunction

endpackage

// File: rtl/inv_permute_stream_inv_swap.sv
// inv_swap: purely combinational inverse lane permutation of one 25-bit slice line.
// Undoes the encoder map (x,y) -> (y, 2x+3y mod 5).
// Ports:
//   din  : permuted line, bit index 5*y+x
//   dout : restored line, dout[5*y+x] = din[5*((2x+3y) mod 5) + y]
module inv_swap
    import inv_permute_stream_pkg::*;
(
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    for (genvar y = 0; y < 5; y++) begin : g_row
        for (genvar x = 0; x < 5; x++) begin : g_col
            localparam int unsigned Dst = idx(x, y);
            localparam int unsigned Src = idx(y, (2 * x + 3 * y) % 5);
            assign dout[Dst] = din[Src];
        end
    end

endmodule

// File: rtl/inv_permute_stream.sv
// inv_permute_stream: consumes a frame of LINES permuted slice lines and emits each one with
// the inverse lane permutation applied, through a one-deep registered output stage.
// Optional feature macro: INV_PERMUTE_BYPASS_EN adds a per-line bypass input.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   start       : frame start pulse (only honoured in idle)
//   in_valid    : line_in valid          in_ready  : line accepted this cycle
//   line_in     : permuted line          line_out  : inverse-permuted line
//   out_valid   : line_out valid         out_ready : downstream accepts line_out
//   bypass      : (macro only) register the accepted line unchanged
//   cnt_value   : lines emitted in the current frame
//   busy        : FSM not idle           done      : one-cycle end-of-frame pulse
module inv_permute_stream
    import inv_permute_stream_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] line_in,
`ifdef INV_PERMUTE_BYPASS_EN
    input  logic             bypass,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] line_out,
    output logic [CNT_W-1:0] cnt_value,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] CntMax  = CNT_W'(LINES);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(LINES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] line_q, line_d;
    logic [WIDTH-1:0] swapped;
    logic [WIDTH-1:0] next_line;
    logic             in_room;
    logic             accept;
    logic             emit;

    inv_swap u_inv_swap (
        .din  (line_in),
        .dout (swapped)
    );

`ifdef INV_PERMUTE_BYPASS_EN
    assign next_line = bypass ? line_in : swapped;
`else
    assign next_line = swapped;
`endif

    assign in_room  = in_cnt_q < CntMax;
    assign emit     = out_valid_q && out_ready;
    // The output register may take a new line whenever it is empty or emptying this cycle.
    assign in_ready = (state_q == StRun) && in_room && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (!in_room) state_d = StDrain;
            // The last line may already have left while still in RUN.
            StDrain: if ((out_cnt_q == CntMax) || (emit && (out_cnt_q == CntLast))) begin
                state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        if (state_q == StDone) begin
            // Leaving DONE always enters IDLE, so clear here.
            in_cnt_d  = '0;
            out_cnt_d = '0;
        end else begin
            if (accept) in_cnt_d = in_cnt_q + 1'b1;
            if (emit) out_cnt_d = out_cnt_q + 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        line_d      = line_q;
        if (accept) begin
            out_valid_d = 1'b1;
            line_d      = next_line;
        end else if (emit) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            line_q      <= '0;
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            out_valid_q <= out_valid_d;
            line_q      <= line_d;
        end
    end

    assign out_valid = out_valid_q;
    assign line_out  = line_q;
    assign cnt_value = out_cnt_q;
    assign busy      = state_q != StIdle;
    assign done      = state_q == StDone;

endmodule

// File: tb/tb_inv_permute_stream.sv
// Self-checking bench for inv_permute_stream: constant vector table, randomized frames against a
// queue-based reference model, backpressure, round trip, mid-frame reset and start-while-busy.
module tb_inv_permute_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        bypass = 1'b0;
    logic [24:0] line_in = '0;
    logic        in_ready, out_valid, busy, done;
    logic [24:0] line_out;
    logic [6:0]  cnt_value;

    always #5 clk = ~clk;

    inv_permute_stream dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .line_in   (line_in),
`ifdef INV_PERMUTE_BYPASS_EN
        .bypass    (bypass),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .line_out  (line_out),
        .cnt_value (cnt_value),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        logic [24:0] din;
        logic [24:0] dout;
    } vec_t;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [24:0] mq[$];
    logic [24:0] src[$];
    logic [24:0] got[$];
    logic [24:0] orig[$];
    bit          m_active = 0;
    int          m_acc = 0;
    int          m_emit = 0;
    int          frame_acc = 0;
    int          n_done = 0;
    bit          last_acc = 0;

    // Reference: each input bit i sits at row a=i/5, column b=i%5 of the permuted grid, i.e. it
    // came from lane (x, y=b) with 2x+3y = a (mod 5); 3 is the inverse of 2 mod 5.
    function automatic logic [24:0] ref_inv(input logic [24:0] v);
        logic [24:0] r;
        int a, b, x;
        r = '0;
        for (int i = 0; i < 25; i++) begin
            a = i / 5;
            b = i % 5;
            x = (3 * (a - 3 * b + 15)) % 5;
            r[5 * b + x] = v[i];
        end
        return r;
    endfunction

    function automatic logic [24:0] ref_fwd(input logic [24:0] v);
        logic [24:0] r;
        r = '0;
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                r[5 * ((2 * x + 3 * y) % 5) + y] = v[5 * y + x];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Checks outputs at the falling edge, advances the model across the next rising edge.
    task automatic cycle();
        logic exp_rdy, acc, emit, was_active;
        @(negedge clk);
        exp_rdy = m_active && (m_acc < 64) && (mq.size() == 0 || out_ready);
        chk("in_ready", in_ready, exp_rdy);
        chk("out_valid", out_valid, mq.size() != 0);
        if (mq.size() != 0) chk("line_out", line_out, mq[0]);
        chk("cnt_value", cnt_value, m_emit);
        chk("busy", busy, m_active);
        if (m_emit < 64) chk("done_early", done, 0);
        acc  = in_valid && exp_rdy;
        emit = (mq.size() != 0) && out_ready;
        last_acc = acc;
        was_active = m_active;
        if (emit) begin
            got.push_back(line_out);
            void'(mq.pop_front());
            m_emit++;
        end
        if (acc) begin
            mq.push_back(bypass ? line_in : ref_inv(line_in));
            m_acc++;
            frame_acc++;
        end
        if (done === 1'b1) begin
            n_done++;
            chk("done_frame_len", frame_acc, 64);
            m_active = 0;
            m_acc = 0;
            m_emit = 0;
            frame_acc = 0;
        end
        if (start && !was_active) m_active = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_line_out", line_out, 0);
        chk("rst_cnt_value", cnt_value, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        mq.delete();
        src.delete();
        m_active = 0;
        m_acc = 0;
        m_emit = 0;
        frame_acc = 0;
        start = 0;
        in_valid = 0;
        out_ready = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // mode: 0 = out_ready held 1, 1 = 5-cycle stall after 20 accepts, 2 = random out_ready.
    task automatic run_frame(input int mode, input bit hold, input bit start_mid,
                             input int abort_at, input bit do_start, output bit aborted);
        int n0, cyc, stall_left;
        bit stalled;
        logic [24:0] held;
        n0 = n_done;
        cyc = 0;
        stall_left = 0;
        stalled = 0;
        held = '0;
        aborted = 0;
        if (do_start) begin
            start = 1;
            in_valid = 0;
            out_ready = 1;
            cycle();
            start = 0;
        end
        while (m_acc < 64 && cyc < 1000) begin
            if (mode == 1 && !stalled && m_acc == 20) begin
                stall_left = 5;
                stalled = 1;
                held = line_out;
            end
            if (mode == 0) out_ready = 1;
            else if (mode == 1) out_ready = (stall_left == 0);
            else out_ready = ($urandom_range(3) != 0);
            in_valid = (src.size() != 0) || hold;
            line_in = (src.size() != 0) ? src[0] : 25'($urandom);
            start = start_mid && (m_acc == 10);
            cycle();
            cyc++;
            start = 0;
            if (stall_left > 0) begin
                stall_left--;
                chk("stall_line", line_out, held);
                chk("stall_valid", out_valid, 1);
            end
            if (last_acc && src.size() != 0) void'(src.pop_front());
            if (abort_at != 0 && m_acc == abort_at) begin
                apply_reset();
                aborted = 1;
                return;
            end
        end
        if (m_acc < 64) chk("accept_timeout", m_acc, 64);
        if (mode == 0 && do_start) chk("accept_cycles", cyc, 64);
        in_valid = hold;
        out_ready = 1;
        cyc = 0;
        while (n_done == n0 && cyc < 20) begin
            line_in = 25'($urandom);
            cycle();
            cyc++;
        end
        chk("done_seen", n_done - n0, 1);
        cycle();
        chk("done_single", n_done - n0, 1);
        chk("idle_after", busy, 0);
        chk("cnt_cleared", cnt_value, 0);
        in_valid = 0;
    endtask

    task automatic fill_random();
        src.delete();
        orig.delete();
        for (int i = 0; i < 64; i++) begin
            orig.push_back(25'($urandom));
            src.push_back(orig[i]);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        bit ab;
        vecs[0] = '{25'h0000001, 25'h0000001};
        vecs[1] = '{25'h0000002, 25'h0000040};
        vecs[2] = '{25'h0000020, 25'h0000008};
        vecs[3] = '{25'h0000080, 25'h0000400};
        vecs[4] = '{25'h1000000, 25'h0200000};
        vecs[5] = '{25'h1FFFFFF, 25'h1FFFFFF};

        #2;
        apply_reset();

        // Valid outside RUN is ignored.
        in_valid = 1;
        line_in = 25'h155;
        out_ready = 1;
        cycle();
        cycle();

        // Table vectors: each result visible one cycle after acceptance.
        start = 1;
        in_valid = 0;
        cycle();
        start = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1;
            line_in = vecs[i].din;
            cycle();
            chk("vec_accepted", last_acc, 1);
            chk("vec_out", line_out, vecs[i].dout);
            chk("vec_valid", out_valid, 1);
        end
        src.delete();
        for (int i = 0; i < 58; i++) src.push_back(25'($urandom));
        run_frame(0, 0, 0, 0, 0, ab);

        // Full frame back to back, in_valid held after the 64th line.
        fill_random();
        run_frame(0, 1, 0, 0, 1, ab);

        // Mid-frame backpressure.
        fill_random();
        run_frame(1, 0, 0, 0, 1, ab);

        // Round trip through the forward map.
        fill_random();
        src.delete();
        for (int i = 0; i < 64; i++) src.push_back(ref_fwd(orig[i]));
        got.delete();
        run_frame(2, 0, 0, 0, 1, ab);
        chk("rt_count", got.size(), 64);
        for (int i = 0; i < 64 && i < got.size(); i++) chk("rt_line", got[i], orig[i]);

        // Reset at line 30, then a fresh frame.
        fill_random();
        run_frame(0, 0, 0, 30, 1, ab);
        chk("aborted", ab, 1);
        fill_random();
        run_frame(2, 0, 0, 0, 1, ab);

        // start while running is ignored.
        fill_random();
        run_frame(2, 1, 1, 0, 1, ab);

`ifdef INV_PERMUTE_BYPASS_EN
        fill_random();
        got.delete();
        bypass = 1;
        run_frame(0, 0, 0, 0, 1, ab);
        bypass = 0;
        for (int i = 0; i < 64 && i < got.size(); i++) chk("bypass_line", got[i], orig[i]);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
